// File: rtl/dict_pkg.sv
// Shared dictionary definitions: op codes, client FSM states and default widths.
// Used by dict_client, its interface and the dictionary itself.
package dict_pkg;

  localparam int DICT_ENTRIES      = 10;
  localparam int DICT_KEY_WIDTH    = 8;
  localparam int DICT_KEY_LENGTH   = 1;
  localparam int DICT_VALUE_WIDTH  = 32;
  localparam int DICT_VALUE_LENGTH = 1;

  localparam logic [2:0] OP_SET         = 3'd0;
  localparam logic [2:0] OP_GET         = 3'd1;
  localparam logic [2:0] OP_ENCODE      = 3'd2;
  localparam logic [2:0] OP_SET_FAST    = 3'd3;
  localparam logic [2:0] OP_GET_FAST    = 3'd4;
  localparam logic [2:0] OP_DELETE      = 3'd5;
  localparam logic [2:0] OP_DELETE_FAST = 3'd6;
  localparam logic [2:0] OP_ILLEGAL     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } client_state_e;

  // Index-addressed ops finish one cycle earlier than key-searching ops
  function automatic logic is_fast_op(input logic [2:0] op);
    case (op)
      OP_SET_FAST, OP_GET_FAST, OP_DELETE_FAST: is_fast_op = 1'b1;
      default:                                  is_fast_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dict_client_if.sv
// Command, dictionary-request and response bundle of dict_client.
// master = the client (drives o_*), slave = its environment (drives i_*).
interface dict_client_if
  import dict_pkg::*;
#(
  parameter int ENTRIES      = DICT_ENTRIES,
  parameter int KEY_WIDTH    = DICT_KEY_WIDTH,
  parameter int KEY_LENGTH   = DICT_KEY_LENGTH,
  parameter int VALUE_WIDTH  = DICT_VALUE_WIDTH,
  parameter int VALUE_LENGTH = DICT_VALUE_LENGTH,
  parameter int IDX_W        = $clog2(ENTRIES)
) ();

  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic [2:0]             i_cmd_op;
  logic [KEY_WIDTH-1:0]   i_cmd_key [KEY_LENGTH];
  logic [IDX_W-1:0]       i_cmd_index;
  logic [VALUE_WIDTH-1:0] i_cmd_value [VALUE_LENGTH];

  logic                   o_dict_en;
  logic                   o_dict_ready;
  logic [2:0]             o_dict_op;
  logic [KEY_WIDTH-1:0]   o_dict_key [KEY_LENGTH];
  logic [IDX_W-1:0]       o_dict_index;
  logic [VALUE_WIDTH-1:0] o_dict_value [VALUE_LENGTH];
  logic [VALUE_WIDTH-1:0] i_dict_value [VALUE_LENGTH];
  logic [IDX_W-1:0]       i_dict_index;
  logic                   i_dict_done;
  logic                   i_dict_err;

  logic                   o_rsp_valid;
  logic                   i_rsp_ready;
  logic [VALUE_WIDTH-1:0] o_rsp_value [VALUE_LENGTH];
  logic [IDX_W-1:0]       o_rsp_index;
  logic                   o_rsp_err;
  logic                   o_rsp_timeout;

  modport master (
    input  i_cmd_valid, i_cmd_op, i_cmd_key, i_cmd_index, i_cmd_value,
    input  i_dict_value, i_dict_index, i_dict_done, i_dict_err, i_rsp_ready,
    output o_cmd_ready, o_dict_en, o_dict_ready, o_dict_op, o_dict_key,
    output o_dict_index, o_dict_value, o_rsp_valid, o_rsp_value, o_rsp_index,
    output o_rsp_err, o_rsp_timeout
  );

  modport slave (
    output i_cmd_valid, i_cmd_op, i_cmd_key, i_cmd_index, i_cmd_value,
    output i_dict_value, i_dict_index, i_dict_done, i_dict_err, i_rsp_ready,
    input  o_cmd_ready, o_dict_en, o_dict_ready, o_dict_op, o_dict_key,
    input  o_dict_index, o_dict_value, o_rsp_valid, o_rsp_value, o_rsp_index,
    input  o_rsp_err, o_rsp_timeout
  );

endinterface

// File: rtl/dict_client_timer.sv
// Loadable down-counter for the dict_client response timeout.
// Holds at zero; o_expired is high whenever the count is zero.
module dict_client_timer #(
  parameter int W        = 4,
  parameter int LOAD_VAL = 14
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  logic [W-1:0] r_count;

  // Load on request, otherwise count down to zero while enabled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= W'(LOAD_VAL);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/dict_client.sv
// Initiator side of the dictionary op protocol: one command in flight, response timeout.
// Optional one-entry GET cache enabled by defining DICT_CLIENT_CACHE_EN.
module dict_client
  import dict_pkg::*;
#(
  parameter int ENTRIES        = DICT_ENTRIES,
  parameter int KEY_WIDTH      = DICT_KEY_WIDTH,
  parameter int KEY_LENGTH     = DICT_KEY_LENGTH,
  parameter int VALUE_WIDTH    = DICT_VALUE_WIDTH,
  parameter int VALUE_LENGTH   = DICT_VALUE_LENGTH,
  parameter int TIMEOUT_CYCLES = 15,
  localparam int IDX_W         = $clog2(ENTRIES),
  localparam int TMR_W         = $clog2(TIMEOUT_CYCLES)
) (
  input logic           i_clk,
  input logic           i_rst,
  dict_client_if.master bus
);

  client_state_e          r_state;
  client_state_e          w_state_nxt;
  logic                   w_cmd_ready;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_timeout;
  logic                   w_expired;
  logic                   w_dict_en_nxt;
  logic [2:0]             w_issue_op;
  logic [IDX_W-1:0]       w_issue_idx;

  logic                   r_dict_en;
  logic                   r_dict_ready;
  logic [2:0]             r_dict_op;
  logic [KEY_WIDTH-1:0]   r_dict_key [KEY_LENGTH];
  logic [IDX_W-1:0]       r_dict_index;
  logic [VALUE_WIDTH-1:0] r_dict_value [VALUE_LENGTH];
  logic                   r_rsp_valid;
  logic [VALUE_WIDTH-1:0] r_rsp_value [VALUE_LENGTH];
  logic [IDX_W-1:0]       r_rsp_index;
  logic                   r_rsp_err;
  logic                   r_rsp_timeout;

  // A stale done from the previous request must clear before the next accept
  assign w_cmd_ready = (r_state == ST_IDLE) && !bus.i_dict_done;

`ifdef DICT_CLIENT_CACHE_EN
  logic                 r_cache_valid;
  logic [KEY_WIDTH-1:0] r_cache_key [KEY_LENGTH];
  logic [IDX_W-1:0]     r_cache_idx;
  logic                 w_key_match;
  logic                 w_cache_hit;
  logic                 w_cache_kill;
  logic                 w_cache_fill;

  // Cache lookup: a GET of the cached key is rewritten to GET_FAST
  always_comb begin
    w_key_match = 1'b1;
    for (int i = 0; i < KEY_LENGTH; i++) begin
      w_key_match = w_key_match && (bus.i_cmd_key[i] == r_cache_key[i]);
    end
    w_cache_hit  = r_cache_valid && (bus.i_cmd_op == OP_GET) && w_key_match;
    w_cache_kill = (bus.i_cmd_op == OP_DELETE) || (bus.i_cmd_op == OP_DELETE_FAST) ||
                   ((bus.i_cmd_op == OP_SET_FAST) && (bus.i_cmd_index == r_cache_idx));
    w_cache_fill = w_capture && !bus.i_dict_err &&
                   ((r_dict_op == OP_GET) || (r_dict_op == OP_ENCODE) || (r_dict_op == OP_SET));
    w_issue_op   = w_cache_hit ? OP_GET_FAST : bus.i_cmd_op;
    w_issue_idx  = w_cache_hit ? r_cache_idx : bus.i_cmd_index;
  end

  // Cache entry: filled on clean completion, dropped on delete or overwrite
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cache_valid <= 1'b0;
      r_cache_idx   <= '0;
      for (int i = 0; i < KEY_LENGTH; i++) r_cache_key[i] <= '0;
    end else if (w_accept && w_cache_kill) begin
      r_cache_valid <= 1'b0;
    end else if (w_cache_fill) begin
      r_cache_valid <= 1'b1;
      r_cache_key   <= r_dict_key;
      r_cache_idx   <= bus.i_dict_index;
    end
  end
`else
  assign w_issue_op  = bus.i_cmd_op;
  assign w_issue_idx = bus.i_cmd_index;
`endif

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_cmd_valid && w_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.i_cmd_op == OP_ILLEGAL) ? ST_RESP : ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.i_dict_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: w_state_nxt = bus.i_rsp_ready ? ST_IDLE : ST_RESP;
      default: w_state_nxt = ST_IDLE;
    endcase
    // Enable stays up through RESP only for requests that reached the dictionary
    w_dict_en_nxt = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT) ||
                    ((w_state_nxt == ST_RESP) && r_dict_en);
  end

  // State and control-output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_dict_en    <= 1'b0;
      r_dict_ready <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dict_en    <= w_dict_en_nxt;
      r_dict_ready <= (w_state_nxt == ST_ISSUE);
      r_rsp_valid  <= (w_state_nxt == ST_RESP);
    end
  end

  // Request latch on accept; response capture on done, timeout or illegal op
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dict_op     <= OP_SET;
      r_dict_index  <= '0;
      r_rsp_index   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      for (int i = 0; i < KEY_LENGTH; i++) r_dict_key[i] <= '0;
      for (int i = 0; i < VALUE_LENGTH; i++) begin
        r_dict_value[i] <= '0;
        r_rsp_value[i]  <= '0;
      end
    end else begin
      if (w_accept && (bus.i_cmd_op != OP_ILLEGAL)) begin
        r_dict_op    <= w_issue_op;
        r_dict_key   <= bus.i_cmd_key;
        r_dict_index <= w_issue_idx;
        r_dict_value <= bus.i_cmd_value;
      end
      if (w_capture) begin
        r_rsp_value   <= bus.i_dict_value;
        r_rsp_index   <= bus.i_dict_index;
        r_rsp_err     <= bus.i_dict_err;
        r_rsp_timeout <= 1'b0;
      end else if (w_timeout || (w_accept && (bus.i_cmd_op == OP_ILLEGAL))) begin
        for (int i = 0; i < VALUE_LENGTH; i++) r_rsp_value[i] <= '0;
        r_rsp_index   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= w_timeout;
      end
    end
  end

  dict_client_timer #(
    .W        (TMR_W),
    .LOAD_VAL (TIMEOUT_CYCLES - 1)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (r_state == ST_ISSUE),
    .i_en      (r_state == ST_WAIT),
    .o_expired (w_expired)
  );

  assign bus.o_cmd_ready   = w_cmd_ready && !i_rst;
  assign bus.o_dict_en     = r_dict_en;
  assign bus.o_dict_ready  = r_dict_ready;
  assign bus.o_dict_op     = r_dict_op;
  assign bus.o_dict_key    = r_dict_key;
  assign bus.o_dict_index  = r_dict_index;
  assign bus.o_dict_value  = r_dict_value;
  assign bus.o_rsp_valid   = r_rsp_valid;
  assign bus.o_rsp_value   = r_rsp_value;
  assign bus.o_rsp_index   = r_rsp_index;
  assign bus.o_rsp_err     = r_rsp_err;
  assign bus.o_rsp_timeout = r_rsp_timeout;

endmodule

// File: doc/dict_client.md
Name: dict_client

Overview:
Initiator side of the dictionary op protocol. It accepts one command at a time from an upstream valid/ready port (parser or interpreter), drives the dictionary request lines, waits for the dictionary's done pulse, and returns value, index and error on a valid/ready response port. It enforces single-outstanding-request ordering and a response timeout.

Parameters:
ENTRIES, 10, dictionary depth; IDX_W = $clog2(ENTRIES)
KEY_WIDTH, 8, bits per key element
KEY_LENGTH, 1, key elements
VALUE_WIDTH, 32, bits per value element
VALUE_LENGTH, 1, value elements
TIMEOUT_CYCLES, 15, maximum WAIT cycles before abort; must be >=3

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_cmd_valid  in  1  upstream command present
o_cmd_ready  out  1  command accepted when valid&ready
i_cmd_op  in  3  op code: SET=0 GET=1 ENCODE=2 SET_FAST=3 GET_FAST=4 DELETE=5 DELETE_FAST=6
i_cmd_key  in  KEY_WIDTH x KEY_LENGTH  key (unpacked array)
i_cmd_index  in  IDX_W  index for fast ops
i_cmd_value  in  VALUE_WIDTH x VALUE_LENGTH  value for SET
o_dict_en  out  1  dictionary enable
o_dict_ready  out  1  request strobe, one cycle
o_dict_op, o_dict_key, o_dict_index, o_dict_value  out  as cmd  registered request fields
i_dict_value  in  VALUE_WIDTH x VALUE_LENGTH  returned value
i_dict_index  in  IDX_W  returned index
i_dict_done  in  1  dictionary done
i_dict_err  in  1  dictionary error
o_rsp_valid  out  1  response present
i_rsp_ready  in  1  response consumed
o_rsp_value, o_rsp_index  out  as dict  captured results
o_rsp_err  out  1  dictionary error OR timeout OR illegal op
o_rsp_timeout  out  1  timeout flag

Behaviour:
- Reset: all outputs 0 (o_dict_en 0, arrays 0); state IDLE; timer 0. Reset mid-request drops it silently; no response is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: o_cmd_ready = 1 only when i_dict_done==0. This blocks issue while a stale done is visible. On accept, latch every cmd field into the o_dict_* registers and go to ISSUE.
- Op 7 (illegal): not forwarded. Go directly to RESP with err=1, timeout=0, value/index 0.
- ISSUE (1 cycle): o_dict_en=1, o_dict_ready=1, then go to WAIT. o_dict_ready is never high for more than one consecutive cycle.
- WAIT: o_dict_en=1, o_dict_ready=0. The timer counts from 0.
  - i_dict_done==1: capture value/index/err into the rsp registers, go to RESP.
  - Fast ops complete with done seen on the 1st WAIT cycle; SET/GET/ENCODE/DELETE complete on the 2nd.
  - If timer reaches TIMEOUT_CYCLES-1 with no done: err=1, timeout=1, value/index 0, go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP: o_rsp_valid=1 and fields held stable until i_rsp_ready. On handshake, deassert o_dict_en and return to IDLE.
- Accept-to-valid latency: fast op 3 cycles, slow op 4 cycles.
- Throughput: at most one command in flight. Back-to-back commands are spaced by at least one cycle for the dictionary's done to clear.
- i_dict_done outside WAIT is ignored.
- o_rsp_err on GET/ENCODE/DELETE miss mirrors i_dict_err exactly.

Optional Feature:
DICT_CLIENT_CACHE_EN.
- With the macro: a one-entry cache holds the last key/index pair that completed without error on GET, ENCODE or SET.
  - A GET whose key equals the cached key is issued as GET_FAST with the cached index, saving one cycle.
  - Any DELETE or DELETE_FAST invalidates the cache. So does a SET_FAST to the cached index, and reset.
- Without the macro: every op is forwarded unchanged and there is no cache logic.

Decomposition:
- Package dict_pkg: op code localparams (OP_SET..OP_DELETE_FAST), client state enum, and the shared key/value width defaults. The existing dictionary switches to this package too.
- One sub-module, dict_client_timer: a loadable down-counter with an expired flag, used for the WAIT timeout.

Test Plan:
- GET after SET key 0x41=0x12345678: responder model raises done on the 2nd WAIT cycle -> rsp value 0x12345678, index 0, err 0, valid 4 cycles after accept.
- GET_FAST index 3 -> o_dict_ready high exactly 1 cycle, rsp valid 3 cycles after accept, index 3.
- GET of absent key 0x7A, dictionary err=1 -> rsp err 1, timeout 0, value 0.
- Responder never asserts done -> after 15 WAIT cycles: rsp err 1, timeout 1. The next command is still accepted and completes normally.
- i_rsp_ready held low 10 cycles -> rsp fields stable, o_cmd_ready 0 throughout; op 7 -> err 1 with no dictionary strobe.
- Reset asserted during WAIT -> all outputs 0 immediately, no rsp_valid; with DICT_CLIENT_CACHE_EN, a repeated GET of 0x41 issues op 4.
